xc_malu_issue: RTL and testbench
================================

Name: xc_malu_issue

Overview:
Initiator/sequencer that drives the XCrypto multi-cycle ALU's valid/ready/flush request interface from the execute stage. It accepts one encoded request per handshake and expands the opcode and pack width into the MALU's one-hot uop/pw lines. It holds operands stable while valid is asserted, captures the 64-bit result on ready, and pulses flush so the MALU returns to its initial state. It then presents a writeback response with backpressure, and supports a watchdog timeout and a pipeline kill.

Parameters:
MAX_CYCLES, 72, max cycles in RUN before timeout abort (must be >= 2)
CW, 7, cycle-counter width; must satisfy 2^CW > MAX_CYCLES

Ports:
clock  in  1  clock
resetn  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when high with req_valid
req_op  in  5  0 div,1 divu,2 rem,3 remu,4 mul,5 mulu,6 mulsu,7 clmul,8 pmul,9 pclmul,10 madd,11 msub,12 macc,13 mmul; 14-31 illegal
req_pw  in  3  0 pw32,1 pw16,2 pw8,3 pw4,4 pw2; 5-7 illegal
req_hi  in  1  narrow ops: return result[63:32] instead of [31:0]
req_rs1/req_rs2/req_rs3  in  32 each  operands
req_rd  in  5  destination tag
kill  in  1  pipeline kill; abandon current op, no response
malu_valid  out  1  MALU inputs valid
malu_flush  out  1  MALU flush
malu_uop  out  14  one-hot, bit i = op i
malu_pw  out  5  one-hot {pw_2,pw_4,pw_8,pw_16,pw_32}
malu_rs1/malu_rs2/malu_rs3  out  32 each  registered operands
malu_result  in  64  MALU result
malu_ready  in  1  MALU done
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rd  out  5  destination tag
rsp_data  out  32  narrow result, or result[31:0] when wide
rsp_data_hi  out  32  result[63:32] when rsp_wide, else 0
rsp_wide  out  1  op 10-13 (two-register writeback)
rsp_err  out  1  illegal op/pw or timeout; data fields 0

Behaviour:
- Reset: resetn low at a clock edge forces state IDLE and clears all registers. While resetn is low, every output is 0, including req_ready. After reset, req_ready=1.
- FSM states: IDLE, RUN, FLUSH, RESP, plus DROP (flush after a kill).
- IDLE: req_ready=1, malu_valid=0, malu_uop=0.
  - kill=1: ignore req_valid and stay in IDLE; kill has priority.
  - Handshake with a legal op/pw: latch op, pw, hi, rs1-3, rd; clear counter; go to RUN.
  - Handshake with an illegal op/pw: latch rd, set err; go to RESP. The MALU is never touched.
- RUN: malu_valid=1. malu_uop, malu_pw and malu_rs* are driven from registers and stay constant. The counter increments every cycle.
  - kill=1: go to DROP; kill has priority over malu_ready.
  - Else malu_ready=1: capture result in the same cycle; go to FLUSH.
  - Else counter==MAX_CYCLES-1: set err; go to FLUSH.
- FLUSH: malu_flush=1 and malu_valid=0 for exactly 1 cycle.
  - kill=1: go to IDLE with no response.
  - Else: go to RESP.
- DROP: malu_flush=1 for 1 cycle, then go to IDLE.
- RESP: rsp_valid=1 with all rsp_* fields held stable until rsp_ready. On the handshake go to IDLE; the next request can be accepted the following cycle.
  - kill=1 in RESP: drop rsp_valid and go to IDLE.
- Result mapping:
  - Narrow ops (0-9): rsp_data = req_hi ? result[63:32] : result[31:0]; rsp_data_hi=0; rsp_wide=0.
  - Wide ops (10-13): rsp_data = result[31:0]; rsp_data_hi = result[63:32]; rsp_wide=1; req_hi ignored.
- Latency: accept at cycle 0, RUN from cycle 1. If malu_ready first rises at cycle N (N>=1), FLUSH is at N+1 and rsp_valid rises at N+2. Minimum interval between accepts is 4 cycles.
- Flush is always issued after any MALU activity (success, timeout or kill). The MALU therefore never sits in its done state across requests.
- malu_ready outside RUN is ignored.
- malu_flush is never asserted together with malu_valid.

Test Plan:
- Stub MALU asserts ready 3 cycles after valid rises, result 0xFFFFFFFE_00000001. Request op=5, pw=0, hi=1, rd=7 -> rsp_valid at cycle 5, rsp_data=0xFFFFFFFE, rsp_rd=7, rsp_wide=0, rsp_err=0; malu_uop=0x0020 and malu_pw=0x01 throughout RUN; one flush pulse.
- op=13, pw=1, same stub with result 0x12345678_9ABCDEF0 -> rsp_wide=1, rsp_data=0x9ABCDEF0, rsp_data_hi=0x12345678; malu_pw=0x02.
- op=20, or op=0 with pw=6 -> malu_valid never high, no flush, rsp_valid at cycle 1 with rsp_err=1 and data 0.
- Stub never asserts ready, MAX_CYCLES=72 -> malu_valid high exactly 72 cycles, one flush, then rsp_err=1.
- kill asserted in the 2nd RUN cycle -> next cycle malu_flush=1, no rsp_valid ever, req_ready=1 two cycles after kill; a following request completes normally.
- rsp_ready held low 10 cycles in RESP -> rsp fields stable and req_ready=0 throughout. Two back-to-back requests (ready after 1 cycle) -> accepts exactly 4 cycles apart when rsp_ready=1. resetn pulsed low mid-RUN -> all outputs 0 next cycle, IDLE after.

Source files
------------

// File: rtl/xc_malu_issue.sv
// Request sequencer for the XCrypto multi-cycle ALU: drives the MALU valid/flush
// handshake, holds operands stable, and returns a registered writeback response.
module xc_malu_issue #(
  parameter int unsigned MAX_CYCLES = 72,
  parameter int unsigned CW         = 7
) (
  input  logic        clock,
  input  logic        resetn,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [2:0]  req_pw,
  input  logic        req_hi,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic [4:0]  req_rd,
  input  logic        kill,

  output logic        malu_valid,
  output logic        malu_flush,
  output logic [13:0] malu_uop,
  output logic [4:0]  malu_pw,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  input  logic [63:0] malu_result,
  input  logic        malu_ready,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_data_hi,
  output logic        rsp_wide,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StFlush,
    StResp,
    StDrop
  } state_e;

  localparam logic [CW-1:0] CntLast = CW'(MAX_CYCLES - 1);

  state_e        state_q, state_d;
  logic [4:0]    op_q, op_d;
  logic [2:0]    pw_q, pw_d;
  logic          hi_q, hi_d;
  logic [31:0]   rs1_q, rs1_d;
  logic [31:0]   rs2_q, rs2_d;
  logic [31:0]   rs3_q, rs3_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   result_q, result_d;
  logic          err_q, err_d;

  logic req_legal;
  logic op_wide;

  assign req_legal = (req_op <= 5'd13) && (req_pw <= 3'd4);
  assign op_wide   = (op_q >= 5'd10);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pw_d     = pw_q;
    hi_d     = hi_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rs3_d    = rs3_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (!kill && req_valid) begin
          rd_d     = req_rd;
          result_d = '0;
          if (req_legal) begin
            op_d    = req_op;
            pw_d    = req_pw;
            hi_d    = req_hi;
            rs1_d   = req_rs1;
            rs2_d   = req_rs2;
            rs3_d   = req_rs3;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = StRun;
          end else begin
            // Illegal encodings bypass the MALU and report an error directly.
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q + CW'(1);
        if (kill) begin
          state_d = StDrop;
        end else if (malu_ready) begin
          result_d = malu_result;
          state_d  = StFlush;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StFlush;
        end
      end
      StFlush: begin
        state_d = kill ? StIdle : StResp;
      end
      StResp: begin
        if (kill || rsp_ready) begin
          state_d = StIdle;
        end
      end
      StDrop: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= StIdle;
      op_q     <= '0;
      pw_q     <= '0;
      hi_q     <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      pw_q     <= pw_d;
      hi_q     <= hi_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rs3_q    <= rs3_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Outputs are forced low while resetn is held, not only after the reset edge.
  always_comb begin
    req_ready   = 1'b0;
    malu_valid  = 1'b0;
    malu_flush  = 1'b0;
    malu_uop    = '0;
    malu_pw     = '0;
    malu_rs1    = '0;
    malu_rs2    = '0;
    malu_rs3    = '0;
    rsp_valid   = 1'b0;
    rsp_rd      = '0;
    rsp_data    = '0;
    rsp_data_hi = '0;
    rsp_wide    = 1'b0;
    rsp_err     = 1'b0;

    if (resetn) begin
      malu_rs1 = rs1_q;
      malu_rs2 = rs2_q;
      malu_rs3 = rs3_q;
      unique case (state_q)
        StIdle: begin
          req_ready = 1'b1;
        end
        StRun: begin
          malu_valid = 1'b1;
          malu_uop   = 14'(1) << op_q;
          malu_pw    = 5'(1) << pw_q;
        end
        StFlush, StDrop: begin
          malu_flush = 1'b1;
        end
        StResp: begin
          rsp_valid = !kill;
          rsp_rd    = rd_q;
          rsp_err   = err_q;
          if (!err_q) begin
            rsp_wide    = op_wide;
            rsp_data    = (!op_wide && hi_q) ? result_q[63:32] : result_q[31:0];
            rsp_data_hi = op_wide ? result_q[63:32] : 32'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_issue.sv
// Directed self-checking bench for xc_malu_issue with a simple stub MALU.
module tb_xc_malu_issue;

  logic        clock;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [2:0]  req_pw;
  logic        req_hi;
  logic [31:0] req_rs1, req_rs2, req_rs3;
  logic [4:0]  req_rd;
  logic        kill;
  logic        malu_valid;
  logic        malu_flush;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3;
  logic [63:0] malu_result;
  logic        malu_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic [31:0] rsp_data_hi;
  logic        rsp_wide;
  logic        rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Stub MALU: ready pulses in the stub_delay-th cycle of valid; 0 means never.
  int          stub_delay = 0;
  logic [63:0] stub_result = '0;
  int          vcnt = 0;

  xc_malu_issue #(
    .MAX_CYCLES(72),
    .CW(7)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_pw      (req_pw),
    .req_hi      (req_hi),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_rs3     (req_rs3),
    .req_rd      (req_rd),
    .kill        (kill),
    .malu_valid  (malu_valid),
    .malu_flush  (malu_flush),
    .malu_uop    (malu_uop),
    .malu_pw     (malu_pw),
    .malu_rs1    (malu_rs1),
    .malu_rs2    (malu_rs2),
    .malu_rs3    (malu_rs3),
    .malu_result (malu_result),
    .malu_ready  (malu_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rd      (rsp_rd),
    .rsp_data    (rsp_data),
    .rsp_data_hi (rsp_data_hi),
    .rsp_wide    (rsp_wide),
    .rsp_err     (rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) vcnt <= malu_valid ? vcnt + 1 : 0;
  assign malu_ready  = (stub_delay != 0) && malu_valid && (vcnt == stub_delay - 1);
  assign malu_result = stub_result;

  // Presents one request and returns on the negedge rsp_valid is first seen
  // (rsp_ready held low); cycle 1 is the first cycle after the accept edge.
  task automatic issue(input logic [4:0] op, input logic [2:0] pw, input logic hi,
                       input logic [4:0] rd, input int delay, input logic [63:0] res,
                       input int budget, output int rsp_cyc, output int nflush,
                       output int nvalid, output int bad);
    logic [13:0] exp_uop;
    logic [4:0]  exp_pw;
    exp_uop = '0;
    exp_pw  = '0;
    if (op < 5'd14) exp_uop[op] = 1'b1;
    if (pw < 3'd5)  exp_pw[pw]  = 1'b1;
    stub_delay  = delay;
    stub_result = res;
    rsp_cyc = -1;
    nflush  = 0;
    nvalid  = 0;
    bad     = 0;
    @(negedge clock);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_pw    = pw;
    req_hi    = hi;
    req_rd    = rd;
    req_rs1   = 32'hA5A5_0001;
    req_rs2   = 32'h5A5A_0002;
    req_rs3   = 32'h0F0F_0003;
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (malu_valid) begin
        nvalid++;
        if (malu_uop !== exp_uop || malu_pw !== exp_pw || malu_rs1 !== 32'hA5A5_0001 ||
            malu_rs2 !== 32'h5A5A_0002 || malu_rs3 !== 32'h0F0F_0003) bad++;
      end
      if (malu_flush) nflush++;
      if (malu_flush && malu_valid) bad++;
      if (rsp_valid) begin
        rsp_cyc = k;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
    end
    n_cmp++;
    if ({malu_valid, malu_flush, rsp_valid, rsp_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0000",
                         {malu_valid, malu_flush, rsp_valid, rsp_err});
    end
    resetn = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_req_ready: got %b want 1", req_ready);
    end
    n_cmp++;
    if (malu_uop !== 14'd0) begin
      n_fail++; $display("FAIL idle_uop: got %h want 0", malu_uop);
    end
  endtask

  task automatic test_narrow();
    int rc, nf, nv, bad;
    issue(5'd5, 3'd0, 1'b1, 5'd7, 3, 64'hFFFF_FFFE_0000_0001, 20, rc, nf, nv, bad);
    n_cmp++;
    if (rc !== 5) begin n_fail++; $display("FAIL narrow_latency: got %0d want 5", rc); end
    n_cmp++;
    if (rsp_data !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL narrow_data: got %h want fffffffe", rsp_data);
    end
    n_cmp++;
    if ({rsp_rd, rsp_wide, rsp_err} !== {5'd7, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL narrow_tag: got rd=%0d wide=%b err=%b want 7 0 0",
                         rsp_rd, rsp_wide, rsp_err);
    end
    n_cmp++;
    if (rsp_data_hi !== 32'd0) begin
      n_fail++; $display("FAIL narrow_data_hi: got %h want 0", rsp_data_hi);
    end
    n_cmp++;
    if (bad !== 0 || nv !== 3) begin
      n_fail++; $display("FAIL narrow_run_lines: got bad=%0d valid=%0d want 0 3", bad, nv);
    end
    n_cmp++;
    if (nf !== 1) begin n_fail++; $display("FAIL narrow_flush: got %0d want 1", nf); end
    finish_rsp();
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL narrow_return_idle: got ready=%b rsp=%b want 1 0",
                         req_ready, rsp_valid);
    end
  endtask

  task automatic test_wide();
    int rc, nf, nv, bad;
    issue(5'd13, 3'd1, 1'b1, 5'd9, 3, 64'h1234_5678_9ABC_DEF0, 20, rc, nf, nv, bad);
    n_cmp++;
    if (rc !== 5) begin n_fail++; $display("FAIL wide_latency: got %0d want 5", rc); end
    n_cmp++;
    if (rsp_wide !== 1'b1) begin n_fail++; $display("FAIL wide_flag: got %b want 1", rsp_wide); end
    n_cmp++;
    if (rsp_data !== 32'h9ABC_DEF0) begin
      n_fail++; $display("FAIL wide_data: got %h want 9abcdef0", rsp_data);
    end
    n_cmp++;
    if (rsp_data_hi !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wide_data_hi: got %h want 12345678", rsp_data_hi);
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL wide_run_lines: got %0d want 0", bad); end
    finish_rsp();
  endtask

  task automatic test_illegal();
    int rc, nf, nv, bad;
    logic [4:0] ops [2];
    logic [2:0] pws [2];
    ops[0] = 5'd20; pws[0] = 3'd0;
    ops[1] = 5'd0;  pws[1] = 3'd6;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], pws[i], 1'b0, 5'd11, 1, 64'hDEAD_BEEF_CAFE_F00D, 10, rc, nf, nv, bad);
      n_cmp++;
      if (rc !== 1) begin n_fail++; $display("FAIL illegal%0d_latency: got %0d want 1", i, rc); end
      n_cmp++;
      if (nv !== 0 || nf !== 0) begin
        n_fail++; $display("FAIL illegal%0d_malu_touched: got valid=%0d flush=%0d want 0 0",
                           i, nv, nf);
      end
      n_cmp++;
      if (rsp_err !== 1'b1 || rsp_rd !== 5'd11) begin
        n_fail++; $display("FAIL illegal%0d_err: got err=%b rd=%0d want 1 11", i, rsp_err, rsp_rd);
      end
      n_cmp++;
      if ({rsp_data, rsp_data_hi, rsp_wide} !== 65'd0) begin
        n_fail++; $display("FAIL illegal%0d_data: got %h %h %b want 0", i, rsp_data,
                           rsp_data_hi, rsp_wide);
      end
      finish_rsp();
    end
  endtask

  task automatic test_timeout();
    int rc, nf, nv, bad;
    issue(5'd0, 3'd0, 1'b0, 5'd2, 0, 64'h0, 100, rc, nf, nv, bad);
    n_cmp++;
    if (nv !== 72) begin n_fail++; $display("FAIL timeout_valid_cycles: got %0d want 72", nv); end
    n_cmp++;
    if (nf !== 1) begin n_fail++; $display("FAIL timeout_flush: got %0d want 1", nf); end
    n_cmp++;
    if (rc !== 74) begin n_fail++; $display("FAIL timeout_latency: got %0d want 74", rc); end
    n_cmp++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'd0) begin
      n_fail++; $display("FAIL timeout_err: got err=%b data=%h want 1 0", rsp_err, rsp_data);
    end
    finish_rsp();
  endtask

  task automatic test_kill();
    int rc, nf, nv, bad;
    int saw_rsp;
    saw_rsp = 0;
    stub_delay = 10;
    @(negedge clock);
    req_valid = 1'b1; req_op = 5'd4; req_pw = 3'd0; req_hi = 1'b0; req_rd = 5'd1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0;
    n_cmp++;
    if (malu_flush !== 1'b1 || malu_valid !== 1'b0) begin
      n_fail++; $display("FAIL kill_flush: got flush=%b valid=%b want 1 0", malu_flush, malu_valid);
    end
    if (rsp_valid) saw_rsp++;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL kill_idle: got %b want 1", req_ready); end
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) saw_rsp++;
      @(negedge clock);
    end
    n_cmp++;
    if (saw_rsp !== 0) begin n_fail++; $display("FAIL kill_no_rsp: got %0d want 0", saw_rsp); end
    issue(5'd6, 3'd2, 1'b0, 5'd12, 2, 64'h0000_0001_8765_4321, 20, rc, nf, nv, bad);
    n_cmp++;
    if (rc !== 4 || rsp_data !== 32'h8765_4321 || rsp_rd !== 5'd12 || bad !== 0) begin
      n_fail++; $display("FAIL kill_followup: got cyc=%0d data=%h rd=%0d bad=%0d want 4 87654321 12 0",
                         rc, rsp_data, rsp_rd, bad);
    end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int rc, nf, nv, bad, unstable;
    unstable = 0;
    issue(5'd4, 3'd0, 1'b0, 5'd3, 2, 64'hAAAA_BBBB_CCCC_DDDD, 20, rc, nf, nv, bad);
    n_cmp++;
    if (rsp_data !== 32'hCCCC_DDDD) begin
      n_fail++; $display("FAIL bp_data: got %h want ccccdddd", rsp_data);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hCCCC_DDDD || rsp_rd !== 5'd3 ||
          rsp_err !== 1'b0 || req_ready !== 1'b0) unstable++;
    end
    n_cmp++;
    if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d want 0", unstable); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int n_acc;
    n_acc = 0;
    acc[0] = 0; acc[1] = 0;
    stub_delay = 1;
    stub_result = 64'h1;
    @(negedge clock);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 5'd4; req_pw = 3'd0; req_hi = 1'b0; req_rd = 5'd5;
    for (int k = 0; k < 20; k++) begin
      if (n_acc == 2) req_valid = 1'b0;
      else if (req_ready) begin
        acc[n_acc] = k;
        n_acc++;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    n_cmp++;
    if (n_acc !== 2 || acc[1] - acc[0] !== 4) begin
      n_fail++; $display("FAIL b2b_interval: got n=%0d gap=%0d want 2 4", n_acc, acc[1] - acc[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic any_out;
    stub_delay = 10;
    @(negedge clock);
    req_valid = 1'b1; req_op = 5'd4; req_pw = 3'd0; req_hi = 1'b0; req_rd = 5'd6;
    req_rs1 = 32'h1111_1111;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    any_out = req_ready | malu_valid | malu_flush | (|malu_uop) | (|malu_pw) | (|malu_rs1) |
              (|malu_rs2) | (|malu_rs3) | rsp_valid | (|rsp_rd) | (|rsp_data) |
              (|rsp_data_hi) | rsp_wide | rsp_err;
    n_cmp++;
    if (any_out !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset_outputs: got %b want 0", any_out);
    end
    resetn = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b1 || malu_valid !== 1'b0 || malu_rs1 !== 32'd0) begin
      n_fail++; $display("FAIL midrun_reset_idle: got ready=%b valid=%b rs1=%h want 1 0 0",
                         req_ready, malu_valid, malu_rs1);
    end
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_pw = '0; req_hi = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; req_rd = '0; kill = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_narrow();
    test_wide();
    test_illegal();
    test_timeout();
    test_kill();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
